// File: rtl/cpm_counter.sv
// cpm_counter: measurement back-end for the critical path monitor.
// Gates the monitor ring oscillator (RO_EN) for a programmable number of
// reference cycles, counts RO_OUT rising edges in their own clock domain,
// then synchronises the static count into COUNT with a valid/ready handshake.
// Optional feature macro: CPM_AVG_EN (four passes, COUNT = floor(sum/4)).
module cpm_counter #(
   parameter int CNT_W      = 16,
   parameter int WIN_W      = 16,
   parameter int SETTLE_CYC = 4
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             START,
   input  logic [WIN_W-1:0] WINDOW,
   input  logic [3:0]       SEL_IN,
   input  logic             RO_OUT,
   input  logic             COUNT_READY,
   output logic             RO_EN,
   output logic [3:0]       SEL,
   output logic             BUSY,
   output logic [CNT_W-1:0] COUNT,
   output logic             COUNT_VALID,
   output logic             OVF
);

   localparam int SET_W = $clog2(SETTLE_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_SETTLE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [WIN_W-1:0]   win_len_q, win_len_d;
   logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
   logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
   logic               cap_cnt_q, cap_cnt_d;
   logic [3:0]         sel_q, sel_d;
   logic               ro_en_q, ro_en_d;
   logic               busy_q, busy_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               ovf_q, ovf_d;
   logic               clr_q, clr_d;
   logic [CNT_W-1:0]   sync1_q, sync2_q;
   logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
`ifdef CPM_AVG_EN
   logic [1:0]         pass_q, pass_d;
   logic [CNT_W+1:0]   acc_q, acc_d;
   logic               ovf_acc_q, ovf_acc_d;
   logic [CNT_W+1:0]   sum;
   logic               ovf_any;
`endif

   // Saturating increment for the oscillator-domain edge counter.
   always_comb begin
      edge_cnt_d = (&edge_cnt_q) ? edge_cnt_q : edge_cnt_q + 1'b1;
   end

   // Edge counter in the RO_OUT domain, cleared by reset or the registered clr.
   always_ff @(posedge RO_OUT or negedge RSTN or posedge clr_q) begin
      if (!RSTN) begin
         edge_cnt_q <= '0;
      end else if (clr_q) begin
         edge_cnt_q <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
      end
   end

   // Next-state and next-output logic of the measurement sequencer.
   always_comb begin
      state_d   = state_q;
      win_len_d = win_len_q;
      win_cnt_d = win_cnt_q;
      set_cnt_d = set_cnt_q;
      cap_cnt_d = cap_cnt_q;
      sel_d     = sel_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
`ifdef CPM_AVG_EN
      pass_d    = pass_q;
      acc_d     = acc_q;
      ovf_acc_d = ovf_acc_q;
      sum       = acc_q + (CNT_W+2)'(sync2_q);
      ovf_any   = ovf_acc_q | (&sync2_q);
`endif
      case (state_q)
         S_IDLE: begin
            if (START) begin
               sel_d     = SEL_IN;
               win_len_d = (WINDOW == '0) ? WIN_W'(1) : WINDOW;
               state_d   = S_CLEAR;
`ifdef CPM_AVG_EN
               pass_d    = '0;
               acc_d     = '0;
               ovf_acc_d = 1'b0;
`endif
            end
         end
         S_CLEAR: begin
            win_cnt_d = win_len_q;
            state_d   = S_RUN;
         end
         S_RUN: begin
            if (win_cnt_q == WIN_W'(1)) begin
               set_cnt_d = SET_W'(SETTLE_CYC);
               state_d   = S_SETTLE;
            end else begin
               win_cnt_d = win_cnt_q - 1'b1;
            end
         end
         S_SETTLE: begin
            if (set_cnt_q == SET_W'(1)) begin
               cap_cnt_d = 1'b0;
               state_d   = S_CAPTURE;
            end else begin
               set_cnt_d = set_cnt_q - 1'b1;
            end
         end
         S_CAPTURE: begin
            if (!cap_cnt_q) begin
               cap_cnt_d = 1'b1;
            end else begin
`ifdef CPM_AVG_EN
               if (pass_q == 2'd3) begin
                  count_d = sum[CNT_W+1:2];
                  ovf_d   = ovf_any;
                  state_d = S_DONE;
               end else begin
                  acc_d     = sum;
                  ovf_acc_d = ovf_any;
                  pass_d    = pass_q + 1'b1;
                  state_d   = S_CLEAR;
               end
`else
               count_d = sync2_q;
               ovf_d   = &sync2_q;
               state_d = S_DONE;
`endif
            end
         end
         S_DONE: begin
            if (valid_q && COUNT_READY) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Outputs are registered from the next state so they align with it.
      ro_en_d = (state_d == S_RUN);
      busy_d  = (state_d != S_IDLE);
      valid_d = (state_d == S_DONE);
      clr_d   = (state_d == S_CLEAR);
   end

   // Reference-clock registers, including the free-running 2-flop synchroniser.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= S_IDLE;
         win_len_q <= '0;
         win_cnt_q <= '0;
         set_cnt_q <= '0;
         cap_cnt_q <= 1'b0;
         sel_q     <= '0;
         ro_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         clr_q     <= 1'b0;
         sync1_q   <= '0;
         sync2_q   <= '0;
`ifdef CPM_AVG_EN
         pass_q    <= '0;
         acc_q     <= '0;
         ovf_acc_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         win_len_q <= win_len_d;
         win_cnt_q <= win_cnt_d;
         set_cnt_q <= set_cnt_d;
         cap_cnt_q <= cap_cnt_d;
         sel_q     <= sel_d;
         ro_en_q   <= ro_en_d;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         clr_q     <= clr_d;
         sync1_q   <= edge_cnt_q;
         sync2_q   <= sync1_q;
`ifdef CPM_AVG_EN
         pass_q    <= pass_d;
         acc_q     <= acc_d;
         ovf_acc_q <= ovf_acc_d;
`endif
      end
   end

   assign RO_EN       = ro_en_q;
   assign SEL         = sel_q;
   assign BUSY        = busy_q;
   assign COUNT       = count_q;
   assign COUNT_VALID = valid_q;
   assign OVF         = ovf_q;

endmodule

// File: tb/tb_cpm_counter.sv
// tb_cpm_counter: randomized self-checking bench for cpm_counter.
// Two instances share stimulus: a 16-bit counter and an 8-bit one that
// exercises saturation. A gated oscillator model stands in for the monitor.
`timescale 1ns/10ps
module tb_cpm_counter;

   localparam int S = 4;
`ifdef CPM_AVG_EN
   localparam int PASSES = 4;
`else
   localparam int PASSES = 1;
`endif

   logic        clk;
   logic        rstn;
   logic        start;
   logic [15:0] window;
   logic [3:0]  sel_in;
   logic        ro_out;
   logic        count_ready;
   logic        ro_en, busy, count_valid, ovf;
   logic [3:0]  sel;
   logic [15:0] count;
   logic        s_ro_en, s_busy, s_valid, s_ovf;
   logic [3:0]  s_sel;
   logic [7:0]  s_count;

   int total = 0;
   int bad   = 0;

   realtime per_base = 2.5;
   int      pass_idx = 0;

   cpm_counter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(S)) u_dut (
      .CLK(clk), .RSTN(rstn), .START(start), .WINDOW(window), .SEL_IN(sel_in),
      .RO_OUT(ro_out), .COUNT_READY(count_ready), .RO_EN(ro_en), .SEL(sel),
      .BUSY(busy), .COUNT(count), .COUNT_VALID(count_valid), .OVF(ovf)
   );

   cpm_counter #(.CNT_W(8), .WIN_W(16), .SETTLE_CYC(S)) u_sat (
      .CLK(clk), .RSTN(rstn), .START(start), .WINDOW(window), .SEL_IN(sel_in),
      .RO_OUT(ro_out), .COUNT_READY(count_ready), .RO_EN(s_ro_en), .SEL(s_sel),
      .BUSY(s_busy), .COUNT(s_count), .COUNT_VALID(s_valid), .OVF(s_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Ring oscillator: runs full periods while gated on; odd passes run at 2x period.
   initial begin
      realtime ph;
      ro_out = 1'b0;
      forever begin
         @(posedge ro_en);
         ph = (pass_idx % 2 == 1) ? 2.0 * per_base : per_base;
         pass_idx++;
         #0.3;
         while (ro_en === 1'b1) begin
            #(ph / 2.0) ro_out = 1'b1;
            #(ph / 2.0) ro_out = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
      total++;
      if (obs > exp + tol || obs < exp - tol) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   // Expected rising edges in one gated pass: window time over oscillator period.
   function automatic longint edges(input int weff, input realtime p);
      return longint'($floor((weff * 10.0) / p));
   endfunction

   task automatic do_meas(input int w, input logic [3:0] s_exp, input realtime per, input int hold);
      int     weff, n, ron, sel_bad, stable_bad;
      longint c, sum16, sum8, exp16, exp8, cmax, snap;
      bit     sat_any;
      weff = (w == 0) ? 1 : w;
      per_base = per;
      pass_idx = 0;
      sum16 = 0; sum8 = 0; cmax = 0; sat_any = 0;
      for (int p = 0; p < PASSES; p++) begin
         c = edges(weff, (p % 2 == 1) ? 2.0 * per : per);
         sum16 += c;
         sum8  += (c > 255) ? 255 : c;
         if (c > 255) sat_any = 1;
         if (c > cmax) cmax = c;
      end
      exp16 = sum16 / PASSES;
      exp8  = sum8 / PASSES;

      count_ready = (hold == 0);
      @(negedge clk);
      start = 1'b1; window = 16'(w); sel_in = s_exp;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; window = 16'($urandom); sel_in = 4'($urandom);
      check("sel_cycle1", sel, s_exp, 0);
      check("busy_cycle1", busy, 1, 0);
      check("ro_en_clear", ro_en, 0, 0);

      n = 0; ron = 0; sel_bad = 0;
      while (!count_valid && n < 2000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (ro_en) ron++;
         if (sel !== s_exp) sel_bad++;
      end
      check("latency", n, PASSES * (weff + S + 3), 0);
      check("ro_en_cycles", ron, PASSES * weff, 0);
      check("sel_hold", sel_bad, 0, 0);
      check("sat_valid", s_valid, 1, 0);
      check("count", count, exp16, 1);
      check("ovf", ovf, 0, 0);
      if (cmax > 257 || (sat_any == 0 && cmax < 250)) begin
         check("sat_count", s_count, exp8, 1);
         check("sat_ovf", s_ovf, sat_any, 0);
      end

      snap = count;
      stable_bad = 0;
      for (int i = 0; i < hold; i++) begin
         if (i == hold / 2) start = 1'b1;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         if (!count_valid || count != snap || !busy) stable_bad++;
      end
      if (hold > 0) check("hold_stable", stable_bad, 0, 0);

      count_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("idle_after_hs", busy, 0, 0);
      check("valid_drop", count_valid, 0, 0);
      count_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("start_ignored", busy, 0, 0);
   endtask

   initial begin
      realtime ptab [4] = '{2.5, 4.0, 5.0, 7.5};
      rstn = 1'b0; start = 1'b0; window = '0; sel_in = '0; count_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ro_en", ro_en, 0, 0);
      check("rst_busy", busy, 0, 0);
      check("rst_count", count, 0, 0);
      check("rst_valid", count_valid, 0, 0);
      check("rst_ovf", ovf, 0, 0);
      check("rst_sel", sel, 0, 0);
      rstn = 1'b1;
      @(negedge clk);

      // Basic run with long handshake hold; 8-bit instance saturates.
      do_meas(100, 4'b0101, 2.5, 20);
      // WINDOW=0 behaves as one cycle.
      do_meas(0, 4'b1010, 2.5, 0);

      // Reset in the middle of a run.
      @(negedge clk);
      start = 1'b1; window = 16'd100; sel_in = 4'b0011;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      check("mid_run_ro_en", ro_en, 1, 0);
      rstn = 1'b0;
      #1;
      check("rst_mid_ro_en", ro_en, 0, 0);
      check("rst_mid_busy", busy, 0, 0);
      check("rst_mid_sel", sel, 0, 0);
      check("rst_mid_valid", count_valid, 0, 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      do_meas(100, 4'b1100, 2.5, 3);

      // Randomized measurements.
      for (int k = 0; k < 10; k++) begin
         do_meas(int'($urandom_range(0, 40)), 4'($urandom), ptab[$urandom_range(0, 3)],
                 int'($urandom_range(0, 5)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
